// File: rtl/mips_core_pkg.sv
// Shared types and sizing for the rename stage: architectural/physical tag
// types and the renamed-instruction record carried by the output register.
package mips_core_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int ARCH_W   = $clog2(NUM_ARCH);
  localparam int PHYS_W   = $clog2(NUM_PHYS);
  localparam int CNT_W    = PHYS_W + 1;

  typedef logic [PHYS_W-1:0] phys_tag_t;
  typedef logic [ARCH_W-1:0] arch_reg_t;

  typedef struct packed {
    phys_tag_t rs_phys;
    phys_tag_t rt_phys;
    phys_tag_t rw_phys;
    phys_tag_t prev_phys;
    logic      uses_rs;
    logic      uses_rt;
    logic      uses_rw;
    logic      rs_busy;
    logic      rt_busy;
  } renamed_instr_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags. Reset preloads NUM_ARCH..NUM_PHYS-1,
// since tags 0..NUM_ARCH-1 start out as the identity architectural mapping.
module rename_free_list
  import mips_core_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  phys_tag_t        push_tag_i,
  input  logic             pop_i,
  output phys_tag_t        head_tag_o,
  output logic [CNT_W-1:0] count_o
);

  phys_tag_t        mem_q [NUM_PHYS];
  phys_tag_t        head_q;
  phys_tag_t        tail_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  // An overflowing push would corrupt the list, so it is dropped.
  assign push_ok = push_i && (count_q != CNT_W'(NUM_PHYS));
  assign pop_ok  = pop_i && (count_q != '0);

  function automatic phys_tag_t ptr_inc(input phys_tag_t p);
    return (p == phys_tag_t'(NUM_PHYS - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: this storage is reset on purpose; its reset contents are the
  // initial free tags, not don't-cares, so it cannot be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        mem_q[i] <= (i < NUM_PHYS - NUM_ARCH) ? phys_tag_t'(NUM_ARCH + i) : '0;
      end
    end else if (push_ok) begin
      mem_q[tail_q] <= push_tag_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= phys_tag_t'(NUM_PHYS - NUM_ARCH);
      count_q <= CNT_W'(NUM_PHYS - NUM_ARCH);
    end else begin
      if (pop_ok)  head_q <= ptr_inc(head_q);
      if (push_ok) tail_q <= ptr_inc(tail_q);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign head_tag_o = mem_q[head_q];
  assign count_o    = count_q;

  overflow_push_a : assert property (
    @(posedge clk) disable iff (rst) push_i |-> (count_q != CNT_W'(NUM_PHYS))
  ) else $error("rename_free_list: push into full free list");

endmodule

// File: rtl/reg_rename.sv
// Single-issue register rename stage: maps sources through the map table,
// allocates a destination tag from the free list and tracks busy bits.
module reg_rename
  import mips_core_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  arch_reg_t        in_rs,
  input  arch_reg_t        in_rt,
  input  arch_reg_t        in_rw,
  input  logic             in_uses_rs,
  input  logic             in_uses_rt,
  input  logic             in_uses_rw,
  output logic             out_valid,
  input  logic             out_ready,
  output phys_tag_t        out_rs_phys,
  output phys_tag_t        out_rt_phys,
  output phys_tag_t        out_rw_phys,
  output phys_tag_t        out_prev_phys,
  output logic             out_uses_rs,
  output logic             out_uses_rt,
  output logic             out_uses_rw,
  output logic             out_rs_busy,
  output logic             out_rt_busy,
  input  logic             wb_valid,
  input  phys_tag_t        wb_phys,
  input  logic             commit_valid,
  input  phys_tag_t        commit_prev_phys,
  output logic [CNT_W-1:0] free_count
);

  phys_tag_t         map_q [NUM_ARCH];
  logic [NUM_PHYS-1:0] busy_q;
  logic [NUM_PHYS-1:0] busy_d;
  renamed_instr_t    out_q;
  renamed_instr_t    instr_d;
  logic              out_valid_q;

  logic      need_alloc;
  logic      xfer;
  logic      pop;
  logic      push;
  phys_tag_t head_tag;
  phys_tag_t rs_tag;
  phys_tag_t rt_tag;

  // r0 is hardwired, so writing it never consumes a tag.
  assign need_alloc = in_uses_rw && (in_rw != '0);
  assign in_ready   = (!out_valid_q || out_ready) && ((free_count != '0) || !need_alloc);
  assign xfer       = in_valid && in_ready;
  assign pop        = xfer && need_alloc;
  assign push       = commit_valid && (commit_prev_phys != '0);

  rename_free_list u_free_list (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_tag_i (commit_prev_phys),
    .pop_i      (pop),
    .head_tag_o (head_tag),
    .count_o    (free_count)
  );

  assign rs_tag = in_uses_rs ? map_q[in_rs] : '0;
  assign rt_tag = in_uses_rt ? map_q[in_rt] : '0;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    instr_d           = '0;
    instr_d.uses_rs   = in_uses_rs;
    instr_d.uses_rt   = in_uses_rt;
    instr_d.uses_rw   = need_alloc;
    instr_d.rs_phys   = rs_tag;
    instr_d.rt_phys   = rt_tag;
    // A same-cycle write-back of the source makes it ready already.
    instr_d.rs_busy   = in_uses_rs && busy_q[rs_tag] && !(wb_valid && wb_phys == rs_tag);
    instr_d.rt_busy   = in_uses_rt && busy_q[rt_tag] && !(wb_valid && wb_phys == rt_tag);
    if (need_alloc) begin
      instr_d.rw_phys   = head_tag;
      instr_d.prev_phys = map_q[in_rw];
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_phys] = 1'b0;
    if (pop)      busy_d[head_tag] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= phys_tag_t'(i);
      busy_q <= '0;
    end else begin
      if (pop) map_q[in_rw] <= head_tag;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      out_q       <= instr_d;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_rs_phys   = out_q.rs_phys;
  assign out_rt_phys   = out_q.rt_phys;
  assign out_rw_phys   = out_q.rw_phys;
  assign out_prev_phys = out_q.prev_phys;
  assign out_uses_rs   = out_q.uses_rs;
  assign out_uses_rt   = out_q.uses_rt;
  assign out_uses_rw   = out_q.uses_rw;
  assign out_rs_busy   = out_q.rs_busy;
  assign out_rt_busy   = out_q.rt_busy;

endmodule

// File: tb/tb_reg_rename.sv
// Directed bench for reg_rename with hand-computed expected tags, busy bits
// and free-list counts.
module tb_reg_rename;
  import mips_core_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  arch_reg_t        in_rs, in_rt, in_rw;
  logic             in_uses_rs, in_uses_rt, in_uses_rw;
  logic             out_valid, out_ready;
  phys_tag_t        out_rs_phys, out_rt_phys, out_rw_phys, out_prev_phys;
  logic             out_uses_rs, out_uses_rt, out_uses_rw;
  logic             out_rs_busy, out_rt_busy;
  logic             wb_valid, commit_valid;
  phys_tag_t        wb_phys, commit_prev_phys;
  logic [CNT_W-1:0] free_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_rename dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_rs            (in_rs),
    .in_rt            (in_rt),
    .in_rw            (in_rw),
    .in_uses_rs       (in_uses_rs),
    .in_uses_rt       (in_uses_rt),
    .in_uses_rw       (in_uses_rw),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_rs_phys      (out_rs_phys),
    .out_rt_phys      (out_rt_phys),
    .out_rw_phys      (out_rw_phys),
    .out_prev_phys    (out_prev_phys),
    .out_uses_rs      (out_uses_rs),
    .out_uses_rt      (out_uses_rt),
    .out_uses_rw      (out_uses_rw),
    .out_rs_busy      (out_rs_busy),
    .out_rt_busy      (out_rt_busy),
    .wb_valid         (wb_valid),
    .wb_phys          (wb_phys),
    .commit_valid     (commit_valid),
    .commit_prev_phys (commit_prev_phys),
    .free_count       (free_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int rs, input int rt, input int rw,
                           input logic urs, input logic urt, input logic urw);
    in_valid   = 1'b1;
    in_rs      = arch_reg_t'(rs);
    in_rt      = arch_reg_t'(rt);
    in_rw      = arch_reg_t'(rw);
    in_uses_rs = urs;
    in_uses_rt = urt;
    in_uses_rw = urw;
  endtask

  task automatic check_out(input string tag, input int rs, input int rt, input int rw,
                           input int prev, input logic rsb, input logic rtb, input int fc);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".rs"},    32'(out_rs_phys), 32'(rs));
    check({tag, ".rt"},    32'(out_rt_phys), 32'(rt));
    check({tag, ".rw"},    32'(out_rw_phys), 32'(rw));
    check({tag, ".prev"},  32'(out_prev_phys), 32'(prev));
    check({tag, ".rsb"},   32'(out_rs_busy), 32'(rsb));
    check({tag, ".rtb"},   32'(out_rt_busy), 32'(rtb));
    check({tag, ".fc"},    32'(free_count), 32'(fc));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rw = '0;
    in_uses_rs = 1'b0; in_uses_rt = 1'b0; in_uses_rw = 1'b0;
    out_ready = 1'b1;
    wb_valid = 1'b0; wb_phys = '0;
    commit_valid = 1'b0; commit_prev_phys = '0;

    #3;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.fc",    32'(free_count), 32'd32);
    check("rst.rw",    32'(out_rw_phys), 32'd0);
    tick();
    rst = 1'b0;

    // add r3,r1,r2
    set_instr(1, 2, 3, 1, 1, 1);
    #1 check("i1.ready", 32'(in_ready), 32'd1);
    tick();
    check_out("i1", 1, 2, 32, 3, 0, 0, 31);
    check("i1.uses_rw", 32'(out_uses_rw), 32'd1);

    // add r4,r3,r3 -- r3 now tag 32, still busy; commit of tag 0 is ignored
    set_instr(3, 3, 4, 1, 1, 1);
    commit_valid = 1'b1; commit_prev_phys = '0;
    tick();
    commit_valid = 1'b0;
    check_out("i2", 32, 32, 33, 4, 1, 1, 30);

    // add r6,r3,r3 with write-back of tag 32 in the same cycle
    set_instr(3, 3, 6, 1, 1, 1);
    wb_valid = 1'b1; wb_phys = 6'd32;
    tick();
    wb_valid = 1'b0;
    check_out("i3", 32, 32, 34, 6, 0, 0, 29);

    // add r5,r5,r0 with simultaneous commit of tag 3
    set_instr(5, 0, 5, 1, 1, 1);
    commit_valid = 1'b1; commit_prev_phys = 6'd3;
    tick();
    commit_valid = 1'b0;
    check_out("i4", 5, 0, 35, 5, 0, 0, 29);

    // write to r0: no allocation
    set_instr(1, 2, 0, 1, 1, 1);
    tick();
    check_out("i5", 1, 2, 0, 0, 0, 0, 29);
    check("i5.uses_rw", 32'(out_uses_rw), 32'd0);

    // store-like: reads r5 (tag 35, busy) and r3 (tag 32, cleared by write-back)
    set_instr(5, 3, 0, 1, 1, 0);
    tick();
    check_out("i6", 35, 32, 0, 0, 1, 0, 29);

    in_valid = 1'b0;
    tick();
    check("idle.valid", 32'(out_valid), 32'd0);

    // drain the free list: 36..63 then the recycled tag 3
    for (int i = 0; i < 29; i++) begin
      set_instr(0, 0, 7, 0, 0, 1);
      tick();
      check("drain.rw", 32'(out_rw_phys), (i < 28) ? 32'(36 + i) : 32'd3);
    end
    check("drain.prev", 32'(out_prev_phys), 32'd63);
    check("drain.fc",   32'(free_count), 32'd0);

    set_instr(1, 0, 0, 1, 0, 0);
    #1 check("empty.store_ready", 32'(in_ready), 32'd1);
    set_instr(0, 0, 8, 0, 0, 1);
    #1 check("empty.write_ready", 32'(in_ready), 32'd0);
    commit_valid = 1'b1; commit_prev_phys = 6'd7;
    tick();
    commit_valid = 1'b0;
    check("stall.valid", 32'(out_valid), 32'd0);
    check("stall.fc",    32'(free_count), 32'd1);
    check("stall.ready", 32'(in_ready), 32'd1);
    tick();
    check_out("i7", 0, 0, 7, 8, 0, 0, 0);

    // backpressure: output held for three cycles, commit of tag 8 in the first
    out_ready = 1'b0;
    set_instr(9, 10, 9, 1, 1, 1);
    commit_valid = 1'b1; commit_prev_phys = 6'd8;
    for (int c = 0; c < 3; c++) begin
      #1 check("hold.ready", 32'(in_ready), 32'd0);
      tick();
      commit_valid = 1'b0;
      check_out("hold", 0, 0, 7, 8, 0, 0, 1);
    end

    // asynchronous reset mid-stall
    #1 rst = 1'b1;
    #1;
    check("mrst.valid", 32'(out_valid), 32'd0);
    check("mrst.fc",    32'(free_count), 32'd32);
    check("mrst.rw",    32'(out_rw_phys), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_out("post", 9, 10, 32, 9, 0, 0, 31);

    in_valid = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_rename.md
Name: reg_rename

Overview:
- Register-renaming stage sitting between the decoder and the physical register file.
- Renames one instruction per cycle: maps architectural rs/rt to physical tags and allocates a fresh physical tag for rw from a free list.
- Tracks per-physical-register busy bits, cleared by write-back.
- Reclaims the previous mapping of rw when the writing instruction commits.

Parameters:
- NUM_ARCH, 32: architectural registers (5-bit index).
- NUM_PHYS, 64: physical registers; tag width PHYS_W = $clog2(NUM_PHYS) = 6.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_rs, in_rt, in_rw  in  5 each  architectural indices.
- in_uses_rs, in_uses_rt, in_uses_rw  in  1 each  operand-use flags.
- out_valid  out  1  renamed instruction valid.
- out_ready  in  1  downstream (reg file / issue) accepts.
- out_rs_phys, out_rt_phys, out_rw_phys, out_prev_phys  out  6 each  physical tags.
- out_uses_rs, out_uses_rt, out_uses_rw  out  1 each  forwarded flags.
- out_rs_busy, out_rt_busy  out  1 each  source not yet written.
- wb_valid  in  1  write-back this cycle.
- wb_phys  in  6  tag written back.
- commit_valid  in  1  instruction retiring with a destination.
- commit_prev_phys  in  6  tag to return to the free list.
- free_count  out  7  entries in the free list.

Behaviour:
- Reset (async, rst=1):
  - map[i] = i for all i.
  - Free list holds tags 32..63 in ascending order, head=0, tail=32, free_count=32.
  - All busy bits 0.
  - out_valid=0; all out_* tags 0; flags 0.
- Allocation needed iff in_uses_rw && in_rw != 0. Writes to r0 never allocate: out_rw_phys=0, out_prev_phys=0, out_uses_rw=0.
- Handshake:
  - in_ready = (!out_valid || out_ready) && (free_count != 0 || no allocation needed).
  - Transfer occurs when in_valid && in_ready.
  - Output is a registered stage with 1-cycle latency; out_* stays stable while out_valid && !out_ready.
- On transfer:
  - Sources are read from map before the same instruction's rw update, so rs == rw yields the old tag.
  - Tag T is popped from the free list head; out_prev_phys = map[in_rw]; map[in_rw] <= T; busy[T] <= 1.
  - Unused sources output tag 0 and busy 0.
- Source busy:
  - out_*_busy = busy[tag], captured at transfer.
  - If wb_valid && wb_phys == source tag in the same cycle, capture busy 0 (write-back bypass).
- Write-back: wb_valid clears busy[wb_phys]. A same-cycle set from allocation of the same tag cannot occur (an allocated tag is never in flight).
- Commit:
  - commit_valid pushes commit_prev_phys at the tail.
  - commit_prev_phys == 0 is ignored (r0 never freed).
- Simultaneous push and pop: both happen and free_count is unchanged.
- Empty list plus same-cycle commit: no bypass; the allocation stalls one cycle.
- Free list:
  - Circular buffer, NUM_PHYS entries, head/tail pointers wrap modulo NUM_PHYS.
  - A push while free_count == NUM_PHYS is a protocol error; guard it with an assertion and drop the push.
- Reset mid-operation: all state returns to reset values immediately; in-flight output is discarded.

Decomposition:
- mips_core package:
  - NUM_ARCH and NUM_PHYS constants.
  - phys_tag_t (logic [PHYS_W-1:0]).
  - arch_reg_t (logic [4:0]).
  - renamed_instr_t struct holding the three tags, prev tag, uses flags and busy flags.
- Sub-module rename_free_list:
  - Circular FIFO with push, pop, head data, count.
  - Reset preloads tags NUM_ARCH..NUM_PHYS-1.
- The map table, busy vector and output register live in reg_rename.

Test Plan:
- Reset, then rename add r3,r1,r2 -> out_rs_phys=1, out_rt_phys=2, out_rw_phys=32, out_prev_phys=3, out_rs_busy=0, out_rt_busy=0, free_count=31.
- Follow with add r4,r3,r3 -> rs/rt phys 32 busy=1, rw=33, prev=4; then wb_valid with wb_phys=32 in the same cycle as the next read of r3 -> busy 0.
- Rename add r5,r5,r0 -> rs phys 5 (old), rw=new tag, prev=5; rt phys 0, busy 0.
- Write to r0 -> no pop, free_count unchanged, out_uses_rw=0.
- 32 allocations with no commits -> free_count=0, in_ready=0 for a writing instruction but 1 for a store-like (no rw). Commit tag 7 -> next cycle free_count=1, the stalled instruction gets rw=7.
- Hold out_ready=0 for 3 cycles -> outputs stable, no extra pops. Assert rst mid-stall -> out_valid=0 at once, map identity, free_count=32.
